// File: rtl/store_align_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_align_unit_if
//  Brief    : Request and memory-bus bundle for store_align_unit.
//             master = the alignment unit, slave = requester/memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface store_align_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [BYTES-1:0]  bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              store_done;
    logic              misalign_exc;

    modport master (
        input  req_valid, req_size, req_addr, req_wdata, bus_ready,
        output req_ready, bus_valid, bus_addr, bus_be, bus_wdata,
               store_done, misalign_exc
    );

    modport slave (
        output req_valid, req_size, req_addr, req_wdata, bus_ready,
        input  req_ready, bus_valid, bus_addr, bus_be, bus_wdata,
               store_done, misalign_exc
    );
endinterface
`default_nettype wire

// File: rtl/store_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : store_align_unit
//  Brief    : Accepts one store request (size, byte address, right-justified
//             data) and issues registered, lane-aligned bus beats. Illegal
//             requests are rejected with a one-cycle misalign_exc pulse.
//             Optional macro SAU_SPLIT_MISALIGNED_EN: misaligned stores are
//             legal and word-crossing ones are split into two beats.
//  Revision : 1.0  initial release
// ============================================================================
module store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    store_align_unit_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
`ifdef SAU_SPLIT_MISALIGNED_EN
    localparam int SPAN  = 2;   // shifted request can spill into the next word
`else
    localparam int SPAN  = 1;   // legal requests never cross a word
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_DONE  = 3'd3,
        S_EXC   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                alive_q;
    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [BYTES-1:0]    bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                store_done_q, store_done_d;
    logic                exc_q, exc_d;
`ifdef SAU_SPLIT_MISALIGNED_EN
    logic                split_q, split_d;
    logic [BYTES-1:0]    be1_q, be1_d;
    logic [DATA_W-1:0]   wdata1_q, wdata1_d;
    logic                w_split;
`endif

    logic [OFF_W-1:0]        w_off;
    logic [ADDR_W-1:0]       w_base;
    logic                    w_size_ill;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic                    w_accept;
    logic [BYTES-1:0]        w_be_n;
    logic [DATA_W-1:0]       w_mask;
    logic [SPAN*BYTES-1:0]   w_be_sh;
    logic [SPAN*DATA_W-1:0]  w_data_sh;

    assign w_off    = bus.req_addr[OFF_W-1:0];
    assign w_base   = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_accept = bus.req_valid && alive_q && (state_q == S_IDLE);

    // Decode the incoming request: legality, lane enables and shifted data
    always_comb begin
        w_be_n = '0;
        w_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < (1 << bus.req_size)) begin
                w_be_n[i]        = 1'b1;
                w_mask[8*i +: 8] = 8'hFF;
            end
        end
        w_size_ill = (32'(bus.req_size) > OFF_W);
        case (bus.req_size)
            2'd1:    w_misaligned = bus.req_addr[0];
            2'd2:    w_misaligned = |bus.req_addr[1:0];
            2'd3:    w_misaligned = |bus.req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
        w_be_sh   = (SPAN*BYTES)'(w_be_n) << w_off;
        w_data_sh = (SPAN*DATA_W)'(bus.req_wdata & w_mask) << {w_off, 3'b000};
`ifdef SAU_SPLIT_MISALIGNED_EN
        w_split   = |w_be_sh[2*BYTES-1:BYTES];
        w_illegal = w_size_ill;
`else
        w_illegal = w_size_ill || w_misaligned;
`endif
    end

    // Next-state and next-output logic; outputs are registered from here
    always_comb begin
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        store_done_d = 1'b0;
        exc_d        = 1'b0;
`ifdef SAU_SPLIT_MISALIGNED_EN
        split_d      = split_q;
        be1_d        = be1_q;
        wdata1_d     = wdata1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        state_d = S_EXC;
                        exc_d   = 1'b1;
                    end else begin
                        state_d     = S_BEAT0;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = w_base;
                        bus_be_d    = w_be_sh[BYTES-1:0];
                        bus_wdata_d = w_data_sh[DATA_W-1:0];
`ifdef SAU_SPLIT_MISALIGNED_EN
                        split_d     = w_split;
                        be1_d       = w_be_sh[2*BYTES-1:BYTES];
                        wdata1_d    = w_data_sh[2*DATA_W-1:DATA_W];
`endif
                    end
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (bus.bus_ready) begin
`ifdef SAU_SPLIT_MISALIGNED_EN
                    if (state_q == S_BEAT0 && split_q) begin
                        state_d     = S_BEAT1;
                        bus_addr_d  = bus_addr_q + ADDR_W'(BYTES);
                        bus_be_d    = be1_q;
                        bus_wdata_d = wdata1_q;
                    end else begin
`else
                    begin
`endif
                        state_d      = S_DONE;
                        bus_valid_d  = 1'b0;
                        bus_addr_d   = '0;
                        bus_be_d     = '0;
                        bus_wdata_d  = '0;
                        store_done_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any pending beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            alive_q      <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            store_done_q <= 1'b0;
            exc_q        <= 1'b0;
`ifdef SAU_SPLIT_MISALIGNED_EN
            split_q      <= 1'b0;
            be1_q        <= '0;
            wdata1_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            alive_q      <= 1'b1;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            store_done_q <= store_done_d;
            exc_q        <= exc_d;
`ifdef SAU_SPLIT_MISALIGNED_EN
            split_q      <= split_d;
            be1_q        <= be1_d;
            wdata1_q     <= wdata1_d;
`endif
        end
    end

    assign bus.req_ready    = alive_q && (state_q == S_IDLE);
    assign bus.bus_valid    = bus_valid_q;
    assign bus.bus_addr     = bus_addr_q;
    assign bus.bus_be       = bus_be_q;
    assign bus.bus_wdata    = bus_wdata_q;
    assign bus.store_done   = store_done_q;
    assign bus.misalign_exc = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_store_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_align_unit
//  Brief    : Scoreboard bench for store_align_unit (DATA_W=32). Stimulus
//             pushes expected beats/pulses; a negedge monitor pops and checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_align_unit;
    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_EXC  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];

    store_align_unit_if #(.DATA_W(32), .ADDR_W(32)) sif ();

    store_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_chk(input int kind);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected event kind %0d: got event expected none at %0t", kind, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event order: got kind %0d expected kind %0d at %0t", kind, e.kind, $time);
            end else if (kind == K_BEAT) begin
                chk("beat addr", sif.bus_addr, e.addr);
                chk("beat be", {28'd0, sif.bus_be}, {28'd0, e.be});
                chk("beat wdata", sif.bus_wdata, e.data);
            end
        end
    endtask

    // Monitor: consume expected events as the DUT presents them
    always @(negedge clk) begin
        if (!reset) begin
            if (sif.bus_valid && sif.bus_ready) pop_chk(K_BEAT);
            if (sif.store_done)                 pop_chk(K_DONE);
            if (sif.misalign_exc)               pop_chk(K_EXC);
            if (!sif.bus_valid) begin
                chk("idle be", {28'd0, sif.bus_be}, 32'd0);
                chk("idle wdata", sif.bus_wdata, 32'd0);
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.be = be; e.data = d;
        q.push_back(e);
    endtask

    // Wait (bounded) for req_ready; called at posedge+1 phase
    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!sif.req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!sif.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got req_ready 0 expected 1", name);
        end
    endtask

    // Present one request; returns at N+1 (posedge+1 after the accept edge)
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        wait_ready("issue");
        sif.req_valid = 1'b1;
        sif.req_size  = sz;
        sif.req_addr  = a;
        sif.req_wdata = d;
        @(posedge clk); #1;
        sif.req_valid = 1'b0;
        sif.req_size  = 2'($urandom);
        sif.req_addr  = $urandom;
        sif.req_wdata = $urandom;
    endtask

    task automatic run_beat(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] wd);
        push(K_BEAT, {a[31:2], 2'b00}, be, wd);
        push(K_DONE, '0, '0, '0);
        issue(sz, a, d);
        chk("latency bus_valid", {31'd0, sif.bus_valid}, 32'd1);
        wait_ready("complete");
    endtask

    task automatic run_exc(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        push(K_EXC, '0, '0, '0);
        issue(sz, a, d);
        chk("exc pulse", {31'd0, sif.misalign_exc}, 32'd1);
        chk("exc no beat", {31'd0, sif.bus_valid}, 32'd0);
        @(posedge clk); #1;
        chk("exc ready back", {31'd0, sif.req_ready}, 32'd1);
    endtask

    task automatic run_split(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] d1);
        push(K_BEAT, {a[31:2], 2'b00}, be0, d0);
        push(K_BEAT, a1, be1, d1);
        push(K_DONE, '0, '0, '0);
        issue(sz, a, d);
        chk("split latency", {31'd0, sif.bus_valid}, 32'd1);
        wait_ready("split complete");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sif.req_valid = 1'b0;
        sif.req_size  = 2'd0;
        sif.req_addr  = '0;
        sif.req_wdata = '0;
        sif.bus_ready = 1'b1;
        #2;
        chk("reset req_ready", {31'd0, sif.req_ready}, 32'd0);
        chk("reset bus_valid", {31'd0, sif.bus_valid}, 32'd0);
        chk("reset bus_addr", sif.bus_addr, 32'd0);
        chk("reset bus_be", {28'd0, sif.bus_be}, 32'd0);
        chk("reset store_done", {31'd0, sif.store_done}, 32'd0);
        chk("reset misalign_exc", {31'd0, sif.misalign_exc}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("ready after reset", {31'd0, sif.req_ready}, 32'd1);

        // Aligned word, byte in top lane, byte/half masking
        run_beat(2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        run_beat(2'd0, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA500_0000);
        run_beat(2'd0, 32'h0000_2001, 32'hFFFF_FF5A, 4'b0010, 32'h0000_5A00);
        run_beat(2'd1, 32'h0000_2000, 32'hABCD_1234, 4'b0011, 32'h0000_1234);

        // Half store stalled by bus_ready low for three cycles
        sif.bus_ready = 1'b0;
        push(K_BEAT, 32'h0000_1000, 4'b1100, 32'h1234_0000);
        push(K_DONE, '0, '0, '0);
        issue(2'd1, 32'h0000_1002, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            chk("stall valid", {31'd0, sif.bus_valid}, 32'd1);
            chk("stall be", {28'd0, sif.bus_be}, 32'h0000_000C);
            chk("stall wdata", sif.bus_wdata, 32'h1234_0000);
            chk("stall req_ready", {31'd0, sif.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        sif.bus_ready = 1'b1;
        wait_ready("stall complete");

        // Illegal size on a 32-bit bus
        run_exc(2'd3, 32'h0000_2000, 32'h1111_2222);

`ifdef SAU_SPLIT_MISALIGNED_EN
        run_split(2'd2, 32'h0000_1003, 32'hDEAD_BEEF, 4'b1000, 32'hEF00_0000,
                  32'h0000_1004, 4'b0111, 32'h00DE_ADBE);
        run_split(2'd1, 32'h0000_1003, 32'h0000_1234, 4'b1000, 32'h3400_0000,
                  32'h0000_1004, 4'b0001, 32'h0000_0012);
        run_split(2'd2, 32'hFFFF_FFFD, 32'hAABB_CCDD, 4'b1110, 32'hBBCC_DD00,
                  32'h0000_0000, 4'b0001, 32'h0000_00AA);
        run_beat(2'd1, 32'h0000_1001, 32'h0000_1234, 4'b0110, 32'h0012_3400);

        // Reset right after the first beat of a split: beat1 and done abandoned
        sif.bus_ready = 1'b0;
        push(K_BEAT, 32'h0000_1000, 4'b1000, 32'hEF00_0000);
        issue(2'd2, 32'h0000_1003, 32'hDEAD_BEEF);
        sif.bus_ready = 1'b1;
        @(posedge clk); #1;
        sif.bus_ready = 1'b0;
        reset = 1'b1;
        #1;
`else
        run_exc(2'd2, 32'h0000_1003, 32'hDEAD_BEEF);
        run_exc(2'd1, 32'h0000_1001, 32'h0000_1234);
        run_exc(2'd2, 32'hFFFF_FFFD, 32'hAABB_CCDD);

        // Reset while a beat is stalled: beat and done abandoned
        sif.bus_ready = 1'b0;
        issue(2'd2, 32'h0000_1000, 32'h0BAD_F00D);
        chk("pre-reset valid", {31'd0, sif.bus_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
`endif
        chk("mid reset bus_valid", {31'd0, sif.bus_valid}, 32'd0);
        chk("mid reset bus_be", {28'd0, sif.bus_be}, 32'd0);
        chk("mid reset bus_wdata", sif.bus_wdata, 32'd0);
        chk("mid reset bus_addr", sif.bus_addr, 32'd0);
        chk("mid reset req_ready", {31'd0, sif.req_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        sif.bus_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready after mid reset", {31'd0, sif.req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // A normal store after the abandoned one
        run_beat(2'd2, 32'h0000_3008, 32'h0102_0304, 4'b1111, 32'h0102_0304);
        repeat (2) @(posedge clk);
        chk("scoreboard drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
